desplazador_serial: RTL and testbench

- Parametrised, sequential rotate/shift unit: one bit position per clock cycle, with a start/ready/valid handshake.
- Successor to the fixed 8-bit combinational rotate-left-2 and shift-right-2 blocks of Laboratorio 1.
- Generalises to word width `ANCHO`, a run-time shift amount and four modes, including arithmetic shift.
- Sits between a stimulus/control source and a result consumer; the Laboratorio testbenches drive it and dump to VCD.

---
 rtl/desplazador_serial.sv | 106 ++++++++++
 tb/tb_desplazador_serial.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/desplazador_serial.sv
// rtl/desplazador_serial.sv - sequential rotate/shift unit, one bit position per clock
// Operand, amount and mode are captured on accept; Resultado only changes on completion.
module desplazador_serial #(
  parameter int ANCHO     = 8,
  parameter int ANCHO_CNT = $clog2(ANCHO)
) (
  input  logic                 Reloj,
  input  logic                 Reset_n,
  input  logic                 Inicio,
  input  logic [ANCHO-1:0]     Palabra,
  input  logic [ANCHO_CNT-1:0] Cantidad,
  input  logic [1:0]           Modo,
  output logic                 Listo,
  output logic [ANCHO-1:0]     Resultado,
  output logic                 Valido
);

  if (ANCHO < 4 || ANCHO > 64 || (ANCHO & (ANCHO - 1)) != 0) begin : g_bad_ancho
    $error("desplazador_serial: ANCHO must be a power of two in 4..64");
  end

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  estado_t                state_q, state_d;
  logic [ANCHO-1:0]       word_q, word_d;
  logic [ANCHO-1:0]       result_q, result_d;
  logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
  logic [1:0]             modo_q, modo_d;
  logic                   valido_q, valido_d;
  logic [ANCHO-1:0]       step;

  // Single-bit move selected by the captured mode
  always_comb begin
    step = word_q;
    case (modo_q)
      2'b00:   step = {word_q[ANCHO-2:0], word_q[ANCHO-1]};
      2'b01:   step = {word_q[0], word_q[ANCHO-1:1]};
      2'b10:   step = {1'b0, word_q[ANCHO-1:1]};
      default: step = {word_q[ANCHO-1], word_q[ANCHO-1:1]};
    endcase
  end

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= REPOSO;
      word_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      modo_q   <= 2'b00;
      valido_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      modo_q   <= modo_d;
      valido_q <= valido_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    modo_d   = modo_q;
    valido_d = 1'b0;
    case (state_q)
      REPOSO: begin
        if (Inicio) begin
          word_d  = Palabra;
          cnt_d   = Cantidad;
          modo_d  = Modo;
          state_d = DESPLAZA;
        end
      end
      DESPLAZA: begin
        if (cnt_q == '0) begin
          result_d = word_q;
          valido_d = 1'b1;
          state_d  = FIN;
        end else begin
          word_d = step;
          cnt_d  = cnt_q - ANCHO_CNT'(1);
        end
      end
      FIN: begin
        state_d = REPOSO;
      end
      default: begin
        state_d = REPOSO;
      end
    endcase
  end

  always_comb begin
    Listo     = (state_q == REPOSO);
    Valido    = valido_q;
    Resultado = result_q;
  end

endmodule

// File: tb/tb_desplazador_serial.sv
// tb/tb_desplazador_serial.sv - directed self-checking bench for desplazador_serial
// Inputs change and outputs are sampled on the falling clock edge.
module tb_desplazador_serial;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Inicio = 1'b0;
  logic [7:0] Palabra = 8'h00;
  logic [2:0] Cantidad = 3'd0;
  logic [1:0] Modo = 2'b00;
  logic       Listo;
  logic [7:0] Resultado;
  logic       Valido;

  int n_pass = 0;
  int n_total = 0;

  desplazador_serial #(.ANCHO(8)) dut (
    .Reloj    (clk),
    .Reset_n  (Reset_n),
    .Inicio   (Inicio),
    .Palabra  (Palabra),
    .Cantidad (Cantidad),
    .Modo     (Modo),
    .Listo    (Listo),
    .Resultado(Resultado),
    .Valido   (Valido)
  );

  always #5 clk = ~clk;

  // Called on a falling edge while idle; returns on the falling edge right after E0.
  task automatic accept(input logic [7:0] w, input logic [2:0] c, input logic [1:0] m,
                        input bit hold);
    Palabra  = w;
    Cantidad = c;
    Modo     = m;
    Inicio   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) Inicio = 1'b0;
  endtask

  task automatic test_reset;
    #1 Reset_n = 1'b0;
    #1;
    n_total++; if (Listo !== 1'b1) $display("FAIL reset_listo got %b exp 1", Listo); else n_pass++;
    n_total++; if (Valido !== 1'b0) $display("FAIL reset_valido got %b exp 0", Valido); else n_pass++;
    n_total++; if (Resultado !== 8'h00) $display("FAIL reset_resultado got %h exp 00", Resultado); else n_pass++;
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    n_total++; if (Listo !== 1'b1) $display("FAIL reset_idle_listo got %b exp 1", Listo); else n_pass++;
  endtask

  task automatic test_rotate;
    logic [7:0] w_t [2] = '{8'hB1, 8'hB1};
    logic [2:0] c_t [2] = '{3'd2, 3'd3};
    logic [1:0] m_t [2] = '{2'b00, 2'b01};
    logic [7:0] e_t [2] = '{8'hC6, 8'h36};
    for (int i = 0; i < 2; i++) begin
      int k;
      k = int'(c_t[i]);
      accept(w_t[i], c_t[i], m_t[i], 1'b0);
      for (int n = 0; n <= k + 2; n++) begin
        if (n > 0) @(negedge clk);
        n_total++;
        if (Listo !== 1'(n == k + 2)) $display("FAIL rot%0d_listo n=%0d got %b exp %b", i, n, Listo, n == k + 2);
        else n_pass++;
        n_total++;
        if (Valido !== 1'(n == k + 1)) $display("FAIL rot%0d_valido n=%0d got %b exp %b", i, n, Valido, n == k + 1);
        else n_pass++;
        if (n == k + 1) begin
          n_total++;
          if (Resultado !== e_t[i]) $display("FAIL rot%0d_resultado got %h exp %h", i, Resultado, e_t[i]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_shift_max;
    logic [1:0] m_t [2] = '{2'b10, 2'b11};
    logic [7:0] e_t [2] = '{8'h01, 8'hFF};
    for (int i = 0; i < 2; i++) begin
      accept(8'h80, 3'd7, m_t[i], 1'b0);
      // Listo must stay low on samples n=0..8 (9 cycles) and rise at n=9
      for (int n = 0; n <= 9; n++) begin
        if (n > 0) @(negedge clk);
        n_total++;
        if (Listo !== 1'(n == 9)) $display("FAIL shr%0d_listo n=%0d got %b exp %b", i, n, Listo, n == 9);
        else n_pass++;
        n_total++;
        if (Valido !== 1'(n == 8)) $display("FAIL shr%0d_valido n=%0d got %b exp %b", i, n, Valido, n == 8);
        else n_pass++;
        if (n == 8) begin
          n_total++;
          if (Resultado !== e_t[i]) $display("FAIL shr%0d_resultado got %h exp %h", i, Resultado, e_t[i]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_zero_and_ignored;
    accept(8'h5A, 3'd0, 2'b11, 1'b0);
    n_total++; if (Listo !== 1'b0) $display("FAIL zero_listo got %b exp 0", Listo); else n_pass++;
    @(negedge clk);
    n_total++; if (Valido !== 1'b1) $display("FAIL zero_valido got %b exp 1", Valido); else n_pass++;
    n_total++; if (Resultado !== 8'h5A) $display("FAIL zero_resultado got %h exp 5a", Resultado); else n_pass++;
    @(negedge clk);
    n_total++; if (Listo !== 1'b1) $display("FAIL zero_idle got %b exp 1", Listo); else n_pass++;

    // Inicio stays high for the whole run; Palabra changes after accept
    accept(8'h0F, 3'd4, 2'b00, 1'b1);
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) Palabra = 8'hFF;
      n_total++;
      if (Listo !== 1'(n == 6)) $display("FAIL hold_listo n=%0d got %b exp %b", n, Listo, n == 6);
      else n_pass++;
      n_total++;
      if (Valido !== 1'(n == 5)) $display("FAIL hold_valido n=%0d got %b exp %b", n, Valido, n == 5);
      else n_pass++;
      if (n >= 5) begin
        n_total++;
        if (Resultado !== 8'hF0) $display("FAIL hold_resultado n=%0d got %h exp f0", n, Resultado);
        else n_pass++;
      end
    end
    // Still-high Inicio is accepted on the first idle edge
    @(negedge clk);
    Inicio = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) @(negedge clk);
      n_total++;
      if (Listo !== 1'(n == 6)) $display("FAIL reacc_listo n=%0d got %b exp %b", n, Listo, n == 6);
      else n_pass++;
      if (n == 5) begin
        n_total++;
        if (Valido !== 1'b1) $display("FAIL reacc_valido got %b exp 1", Valido); else n_pass++;
        n_total++;
        if (Resultado !== 8'hFF) $display("FAIL reacc_resultado got %h exp ff", Resultado); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    accept(8'hA5, 3'd7, 2'b10, 1'b0);
    repeat (3) @(negedge clk);
    #1 Reset_n = 1'b0;
    #1;
    n_total++; if (Listo !== 1'b1) $display("FAIL midrst_listo got %b exp 1", Listo); else n_pass++;
    n_total++; if (Valido !== 1'b0) $display("FAIL midrst_valido got %b exp 0", Valido); else n_pass++;
    n_total++; if (Resultado !== 8'h00) $display("FAIL midrst_resultado got %h exp 00", Resultado); else n_pass++;
    @(negedge clk);
    Reset_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      n_total++;
      if (Valido !== 1'b0 || Listo !== 1'b1)
        $display("FAIL midrst_quiet n=%0d got valido=%b listo=%b exp 0/1", n, Valido, Listo);
      else n_pass++;
    end
    accept(8'h01, 3'd1, 2'b00, 1'b0);
    for (int n = 0; n <= 3; n++) begin
      if (n > 0) @(negedge clk);
      n_total++;
      if (Valido !== 1'(n == 2)) $display("FAIL post_valido n=%0d got %b exp %b", n, Valido, n == 2);
      else n_pass++;
      if (n == 2) begin
        n_total++;
        if (Resultado !== 8'h02) $display("FAIL post_resultado got %h exp 02", Resultado); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_shift_max();
    test_zero_and_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
